// File: rtl/regfile_onehot.sv
// 32-entry register file with one-hot addressed read/write ports, registered reads,
// write-to-read bypass, hardwired zero register and a sticky select-error flag.
module regfile_onehot #(
   parameter int WIDTH    = 64,
   parameter int ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      asel,
   input  logic [31:0]      bsel,
   input  logic [31:0]      dsel,
   input  logic             we,
   input  logic [WIDTH-1:0] dbus,
   input  logic             rd_en,
   output logic [WIDTH-1:0] abus,
   output logic [WIDTH-1:0] bbus,
   output logic             sel_err
);

   logic [WIDTH-1:0] rf_q [32];
   logic [WIDTH-1:0] rf_d [32];
   logic [WIDTH-1:0] abus_q, abus_d;
   logic [WIDTH-1:0] bbus_q, bbus_d;
   logic             sel_err_q, sel_err_d;

   logic             a_ok, b_ok, d_ok, wr_ok;
   logic [WIDTH-1:0] a_rd, b_rd;

   function automatic logic is_onehot(input logic [31:0] s);
      return (s != 32'd0) && ((s & (s - 32'd1)) == 32'd0);
   endfunction

   always_comb begin
      a_ok  = is_onehot(asel);
      b_ok  = is_onehot(bsel);
      d_ok  = is_onehot(dsel);
      wr_ok = we && d_ok;

      // Reads see rf_d, so a same-edge write is forwarded to the bus for free.
      for (int i = 0; i < 32; i++) begin
         rf_d[i] = (wr_ok && dsel[i] && (i != ZERO_REG)) ? dbus : rf_q[i];
      end

      a_rd = '0;
      b_rd = '0;
      for (int i = 0; i < 32; i++) begin
         if (asel[i] && (i != ZERO_REG)) a_rd = a_rd | rf_d[i];
         if (bsel[i] && (i != ZERO_REG)) b_rd = b_rd | rf_d[i];
      end
      if (!a_ok) a_rd = '0;
      if (!b_ok) b_rd = '0;

      abus_d = rd_en ? a_rd : abus_q;
      bbus_d = rd_en ? b_rd : bbus_q;

      sel_err_d = sel_err_q
                | (we && !d_ok)
                | (rd_en && (!a_ok || !b_ok));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
         abus_q    <= '0;
         bbus_q    <= '0;
         sel_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
         abus_q    <= abus_d;
         bbus_q    <= bbus_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign abus    = abus_q;
   assign bbus    = bbus_q;
   assign sel_err = sel_err_q;

endmodule

// File: tb/tb_regfile_onehot.sv
// Scoreboard bench for regfile_onehot: stimulus pushes expected bus/flag values,
// a monitor pops and compares them one edge later.
module tb_regfile_onehot;

   logic        clk;
   logic        reset_n;
   logic [31:0] asel, bsel, dsel;
   logic        we, rd_en;
   logic [63:0] dbus;
   logic [63:0] abus, bbus;
   logic        sel_err;

   regfile_onehot dut (
      .clk(clk), .reset_n(reset_n), .asel(asel), .bsel(bsel), .dsel(dsel),
      .we(we), .dbus(dbus), .rd_en(rd_en), .abus(abus), .bbus(bbus),
      .sel_err(sel_err)
   );

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        e;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;

   logic [63:0] mdl [32];
   logic [63:0] exp_a = '0;
   logic [63:0] exp_b = '0;
   logic        exp_err = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int low_idx(input logic [31:0] s);
      for (int i = 0; i < 32; i++) if (s[i]) return i;
      return -1;
   endfunction

   function automatic logic [63:0] model_read(input logic [31:0] s, input bit wr,
                                              input int di, input logic [63:0] db);
      int k;
      if ($countones(s) != 1) return 64'd0;
      k = low_idx(s);
      if (k == 31) return 64'd0;
      if (wr && k == di) return db;
      return mdl[k];
   endfunction

   task automatic drive(input logic rn, input logic w, input logic [31:0] d,
                        input logic [63:0] db, input logic rd,
                        input logic [31:0] a, input logic [31:0] b);
      bit   wr;
      int   di;
      exp_t e;
      @(negedge clk);
      reset_n = rn; we = w; dsel = d; dbus = db; rd_en = rd; asel = a; bsel = b;
      if (!rn) begin
         for (int i = 0; i < 32; i++) mdl[i] = '0;
         exp_a = '0; exp_b = '0; exp_err = 1'b0;
      end else begin
         di = low_idx(d);
         wr = w && ($countones(d) == 1) && (di != 31);
         if (rd) begin
            exp_a = model_read(a, wr, di, db);
            exp_b = model_read(b, wr, di, db);
            if ($countones(a) != 1 || $countones(b) != 1) exp_err = 1'b1;
         end
         if (w && $countones(d) != 1) exp_err = 1'b1;
         if (wr) mdl[di] = db;
      end
      e.a = exp_a; e.b = exp_b; e.e = exp_err;
      sb.push_back(e);
   endtask

   task automatic idle(input logic rd, input logic [31:0] a, input logic [31:0] b);
      drive(1'b1, 1'b0, 32'd1, 64'd0, rd, a, b);
   endtask

   // Monitor: every registered output is valid one edge after its stimulus.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (abus !== e.a) begin
               failures++;
               $display("FAIL abus t=%0t got=%h want=%h", $time, abus, e.a);
            end
            checks++;
            if (bbus !== e.b) begin
               failures++;
               $display("FAIL bbus t=%0t got=%h want=%h", $time, bbus, e.b);
            end
            checks++;
            if (sel_err !== e.e) begin
               failures++;
               $display("FAIL sel_err t=%0t got=%b want=%b", $time, sel_err, e.e);
            end
         end
      end
   end

   function automatic logic [31:0] rand_sel();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return 32'd0;
      if (r == 1) return $urandom() | 32'h0000_0003;
      if (r < 10) return 32'd1 << $urandom_range(0, 7);
      if (r == 10) return 32'd1 << 31;
      return 32'd1 << $urandom_range(0, 31);
   endfunction

   initial begin
      reset_n = 1'b0; we = 1'b0; dsel = 32'd1; dbus = '0; rd_en = 1'b0;
      asel = 32'd1; bsel = 32'd1;
      for (int i = 0; i < 32; i++) mdl[i] = '0;

      // Reset drops a write presented alongside it.
      drive(1'b0, 1'b1, 32'd1 << 3, 64'hFFFF, 1'b1, 32'd1 << 3, 32'd1 << 3);
      drive(1'b0, 1'b1, 32'd1 << 3, 64'hFFFF, 1'b1, 32'd1 << 3, 32'd1 << 3);
      idle(1'b1, 32'd1 << 3, 32'd1 << 3);

      // Write then read X5 on both ports.
      drive(1'b1, 1'b1, 32'd1 << 5, 64'h0123_4567_89AB_CDEF, 1'b0, 32'd1, 32'd1);
      idle(1'b1, 32'd1 << 5, 32'd1 << 5);

      // Zero register ignores writes and reads back 0.
      drive(1'b1, 1'b1, 32'd1 << 31, 64'hDEAD, 1'b0, 32'd1, 32'd1);
      idle(1'b1, 32'd1 << 31, 32'd1 << 31);

      // Bypass on port A, then plain read on port B.
      drive(1'b1, 1'b1, 32'd1 << 7, 64'h11, 1'b0, 32'd1, 32'd1);
      drive(1'b1, 1'b1, 32'd1 << 7, 64'h22, 1'b1, 32'd1 << 7, 32'd1 << 5);
      idle(1'b1, 32'd1 << 5, 32'd1 << 7);
      // Both ports bypassing at once.
      drive(1'b1, 1'b1, 32'd1 << 9, 64'h99, 1'b1, 32'd1 << 9, 32'd1 << 9);

      // Stall: bus holds while X2 is overwritten, then picks up the new value.
      drive(1'b1, 1'b1, 32'd1 << 2, 64'hAA, 1'b0, 32'd1, 32'd1);
      idle(1'b1, 32'd1 << 2, 32'd1 << 2);
      drive(1'b1, 1'b1, 32'd1 << 2, 64'hBB, 1'b0, 32'd1 << 2, 32'd1 << 2);
      idle(1'b0, 32'h0000_0006, 32'd0);
      idle(1'b1, 32'd1 << 2, 32'd1 << 2);

      // Bad read select sets the sticky flag until reset.
      idle(1'b1, 32'h0000_0006, 32'd1 << 5);
      for (int i = 0; i < 5; i++) idle(1'b1, 32'd1 << 5, 32'd1 << 2);
      drive(1'b0, 1'b0, 32'd1, 64'd0, 1'b0, 32'd1, 32'd1);
      idle(1'b1, 32'd1 << 5, 32'd1 << 2);

      // Bad write select alone also sets the flag.
      drive(1'b1, 1'b1, 32'd0, 64'h5555, 1'b1, 32'd1 << 1, 32'd1 << 1);
      drive(1'b0, 1'b0, 32'd1, 64'd0, 1'b0, 32'd1, 32'd1);

      // Randomised traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         logic        rn, w, rd;
         logic [31:0] d, a, b;
         logic [63:0] db;
         rn = ($urandom_range(0, 99) != 0);
         w  = ($urandom_range(0, 2) != 0);
         rd = ($urandom_range(0, 4) != 0);
         d  = rand_sel();
         a  = rand_sel();
         b  = rand_sel();
         db = {$urandom(), $urandom()};
         drive(rn, w, d, db, rd, a, b);
      end

      idle(1'b1, 32'd1, 32'd1);
      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain leftover=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_onehot.md
Name: regfile_onehot

Overview:
- Downstream consumer of the Rn/Rm/Rd one-hot select decoders in the ID stage.
- Holds 32 general registers of WIDTH bits. Two read ports are addressed by 32-bit one-hot selects, and one write port is addressed by a one-hot select driven back from the WB stage.
- Read data is registered, giving one cycle of latency into the ID/EX pipeline boundary. Register 31 is the hardwired zero register (XZR).

Parameters:
- WIDTH, 64, data width of each register and of the read/write buses.
- ZERO_REG, 31, index of the hardwired-zero register.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- asel  input  32  one-hot read select, port A (Rn).
- bsel  input  32  one-hot read select, port B (Rm/Rt).
- dsel  input  32  one-hot write select (Rd from WB).
- we  input  1  write enable.
- dbus  input  WIDTH  write data.
- rd_en  input  1  read strobe; when low, abus/bbus hold their value (ID stall).
- abus  output  WIDTH  registered read data, port A.
- bbus  output  WIDTH  registered read data, port B.
- sel_err  output  1  sticky flag: a select was not exactly one-hot.

Behaviour:
- Reset: when reset_n=0 at a rising edge, all 32 registers, abus, bbus and sel_err become 0. Reset has priority over every other input. A write presented in the reset cycle is dropped.
- Write: at a rising edge with we=1 and dsel exactly one-hot at bit k (k != ZERO_REG), register k takes dbus.
  - A write to ZERO_REG is silently ignored.
  - we=1 with dsel=0 or multi-hot writes nothing and sets sel_err.
- Read: at a rising edge with rd_en=1, abus takes the value of the register selected by asel; bbus likewise from bsel.
  - Latency is one cycle from select to bus.
  - Selecting ZERO_REG always yields 0.
- Bypass: if the write and the read happen in the same edge (we=1, dsel one-hot k != ZERO_REG, asel or bsel one-hot at k), the bus takes dbus, not the stale register value. Both ports may bypass in the same cycle.
- rd_en=0: abus and bbus hold. Writes still occur. When rd_en later returns high, the read reflects all writes that happened in between.
- Select not exactly one-hot on a read port while rd_en=1:
  - The corresponding bus loads 0.
  - sel_err sets.
- sel_err behaviour:
  - It is evaluated only for ports in use: asel/bsel when rd_en=1, dsel when we=1.
  - Once set, it stays 1 until reset.
- Register contents are otherwise retained indefinitely. No X propagation is allowed: every register has a defined value after reset.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with we=1, dsel=1<<3, dbus=64'hFFFF → after release, reading asel=1<<3 gives abus=0; sel_err=0.
- Write then read: write 64'h0123_4567_89AB_CDEF to X5. Next cycle set asel=1<<5, bsel=1<<5, rd_en=1 → one edge later abus=bbus=64'h0123_4567_89AB_CDEF.
- Zero register: write 64'hDEAD to X31, then read asel=1<<31 → abus=0; sel_err stays 0.
- Bypass: X7 holds 64'h11. In one cycle drive we=1, dsel=1<<7, dbus=64'h22, asel=1<<7 → abus=64'h22 after that edge, not 64'h11. bbus reading X7 the next cycle also gives 64'h22.
- Stall: abus=64'hAA from X2. Set rd_en=0, write 64'hBB to X2 → abus holds 64'hAA. Raise rd_en → abus=64'hBB one edge later.
- Bad select: asel=32'h0000_0006 with rd_en=1 → abus=0 and sel_err=1. sel_err is still 1 after 5 further clean cycles, and returns to 0 only after reset_n=0.
